// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared constants and types for the 8259 request/service stage
// Holds the request-line count, the reset lowest-priority level, the level type,
// the acknowledge FSM state type and a priority-rank helper.
package pic_pkg;

  localparam int NUM_IR = 8;

  typedef logic [2:0] level_t;

  // Default lowest level 7 makes IR0 the highest priority.
  localparam level_t RESET_LOWEST = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    ACK1 = 1'b1
  } ack_state_t;

  // Position of a level in the current rotation: 0 = highest priority.
  function automatic level_t pri_rank(level_t lvl, level_t low);
    return lvl - low - 3'd1;
  endfunction

endpackage

// File: rtl/pic_rotating_priority_encoder.sv
// rtl/pic_rotating_priority_encoder.sv - first set bit in rotating priority order
// Ports: req (request vector), lowest (lowest-priority level),
//        found (any bit set), level (highest-priority set bit).
module pic_rotating_priority_encoder
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] req,
  input  level_t            lowest,
  output logic              found,
  output level_t            level
);

  level_t idx;

  // Scan starts just above 'lowest' and wraps; the 8th step lands on 'lowest'.
  always_comb begin
    found = 1'b0;
    level = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_IR; k++) begin
      idx = lowest + level_t'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        level = idx;
      end
    end
  end

endmodule

// File: rtl/pic_priority_resolver.sv
// rtl/pic_priority_resolver.sv - 8259 IRR/ISR tracking, priority resolution and EOI
// Ports: CLK/RESET (sync active-high), IR request lines, LEVEL trigger mode,
//        interrupt_mask, INTA_ acknowledge, AEOI/R modes, EOI_CMD/EOI_SPECIFIC,
//        SET_PRI/CMD_LEVEL commands; outputs INTERNAL_INT, IR_NUM, IRR, ISR.
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_IR-1:0] IR,
  input  logic              LEVEL,
  input  logic [NUM_IR-1:0] interrupt_mask,
  input  logic              INTA_,
  input  logic              AEOI,
  input  logic              R,
  input  logic              EOI_CMD,
  input  logic              EOI_SPECIFIC,
  input  logic              SET_PRI,
  input  level_t            CMD_LEVEL,
  output logic              INTERNAL_INT,
  output level_t            IR_NUM,
  output logic [NUM_IR-1:0] IRR,
  output logic [NUM_IR-1:0] ISR
);

  logic [NUM_IR-1:0] irr, isr, ir_prev;
  logic              inta_prev, spurious, internal_int;
  level_t            ir_num, lowest;
  ack_state_t        state;

  logic              cand_found, svc_found;
  level_t            cand_level, svc_level;

  pic_rotating_priority_encoder u_req_enc (
    .req    (irr & ~interrupt_mask),
    .lowest (lowest),
    .found  (cand_found),
    .level  (cand_level)
  );

  pic_rotating_priority_encoder u_svc_enc (
    .req    (isr),
    .lowest (lowest),
    .found  (svc_found),
    .level  (svc_level)
  );

  logic              inta_fall, first_ack, second_ack, cand_wins, eoi_rotate;
  logic [NUM_IR-1:0] ack_set, eoi_clear, aeoi_clear, irr_next, isr_next;
  level_t            lowest_next, eoi_level;
  ack_state_t        state_next;

  always_comb begin
    inta_fall  = inta_prev & ~INTA_;
    first_ack  = inta_fall && (state == IDLE);
    second_ack = inta_fall && (state == ACK1);

    cand_wins = cand_found &&
                (!svc_found || (pri_rank(cand_level, lowest) < pri_rank(svc_level, lowest)));

    ack_set = '0;
    if (first_ack && cand_found)
      ack_set = 8'b0000_0001 << cand_level;

    eoi_clear  = '0;
    eoi_rotate = 1'b0;
    eoi_level  = CMD_LEVEL;
    if (EOI_CMD) begin
      if (EOI_SPECIFIC) begin
        eoi_clear  = 8'b0000_0001 << CMD_LEVEL;
        eoi_rotate = R;
      end else if (svc_found) begin
        eoi_clear  = 8'b0000_0001 << svc_level;
        eoi_rotate = R;
        eoi_level  = svc_level;
      end
    end

    aeoi_clear = '0;
    if (second_ack && AEOI && !spurious)
      aeoi_clear = 8'b0000_0001 << ir_num;

    // Acknowledge set is applied last so it wins over an EOI of the same bit.
    isr_next = (isr & ~eoi_clear & ~aeoi_clear) | ack_set;

    // Acknowledge clears the granted bit, but a fresh edge on it re-arms it.
    if (LEVEL)
      irr_next = IR & ~ack_set;
    else
      irr_next = (irr & ~ack_set) | (IR & ~ir_prev);

    lowest_next = lowest;
    if (eoi_rotate)
      lowest_next = eoi_level;
    else if (SET_PRI)
      lowest_next = CMD_LEVEL;
    else if (second_ack && AEOI && R)
      lowest_next = ir_num;

    state_next = state;
    if (first_ack)
      state_next = ACK1;
    else if (second_ack)
      state_next = IDLE;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      irr          <= '0;
      isr          <= '0;
      ir_num       <= '0;
      internal_int <= 1'b0;
      lowest       <= RESET_LOWEST;
      ir_prev      <= '0;
      inta_prev    <= 1'b1;
      spurious     <= 1'b0;
      state        <= IDLE;
    end else begin
      irr       <= irr_next;
      isr       <= isr_next;
      lowest    <= lowest_next;
      ir_prev   <= IR;
      inta_prev <= INTA_;
      state     <= state_next;
      if (first_ack) begin
        ir_num   <= cand_found ? cand_level : level_t'(3'd7);
        spurious <= ~cand_found;
      end
      // Held low for the whole time the FSM sits in ACK1.
      internal_int <= cand_wins && (state_next == IDLE);
    end
  end

  assign INTERNAL_INT = internal_int;
  assign IR_NUM       = ir_num;
  assign IRR          = irr;
  assign ISR          = isr;

endmodule

// File: tb/tb_pic_priority_resolver.sv
// tb/tb_pic_priority_resolver.sv - self-checking bench for pic_priority_resolver
module tb_pic_priority_resolver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] ir = '0;
  logic       level = 1'b0;
  logic [7:0] mask = '0;
  logic       inta_n = 1'b1;
  logic       aeoi = 1'b0;
  logic       rot = 1'b0;
  logic       eoi_cmd = 1'b0;
  logic       eoi_specific = 1'b0;
  logic       set_pri = 1'b0;
  logic [2:0] cmd_level = '0;
  logic       internal_int;
  logic [2:0] ir_num;
  logic [7:0] irr, isr;

  int checks = 0;
  int failures = 0;

  pic_priority_resolver dut (
    .CLK            (clk),
    .RESET          (reset),
    .IR             (ir),
    .LEVEL          (level),
    .interrupt_mask (mask),
    .INTA_          (inta_n),
    .AEOI           (aeoi),
    .R              (rot),
    .EOI_CMD        (eoi_cmd),
    .EOI_SPECIFIC   (eoi_specific),
    .SET_PRI        (set_pri),
    .CMD_LEVEL      (cmd_level),
    .INTERNAL_INT   (internal_int),
    .IR_NUM         (ir_num),
    .IRR            (irr),
    .ISR            (isr)
  );

  always #5 clk = ~clk;

  // Reference model: priority list walked by position, registers as bit arrays.
  bit [7:0] m_irr, m_isr, m_prev_ir;
  int       m_ir_num, m_low;
  bit       m_int, m_inta_prev, m_in_ack, m_spur;
  bit       started = 0;

  function automatic int top_of(bit [7:0] v, int low);
    for (int p = 0; p < 8; p++) begin
      int l;
      l = (low + 1 + p) % 8;
      if (v[l]) return l;
    end
    return -1;
  endfunction

  function automatic int rank_of(int l, int low);
    return (l - low + 7) % 8;
  endfunction

  always @(posedge clk) begin
    int cand, svc, n_low, eoi_lvl, n_ir_num;
    bit fall, first, second, want, eoi_rot, n_in_ack, n_spur;
    bit [7:0] n_irr, n_isr;
    started <= 1;
    if (reset) begin
      m_irr = 0; m_isr = 0; m_ir_num = 0; m_int = 0;
      m_low = 7; m_prev_ir = 0; m_inta_prev = 1; m_in_ack = 0; m_spur = 0;
    end else begin
      cand   = top_of(m_irr & ~mask, m_low);
      svc    = top_of(m_isr, m_low);
      fall   = m_inta_prev && !inta_n;
      first  = fall && !m_in_ack;
      second = fall && m_in_ack;
      want   = (cand >= 0) && (svc < 0 || rank_of(cand, m_low) < rank_of(svc, m_low));
      n_isr = m_isr; n_low = m_low; n_in_ack = m_in_ack;
      n_ir_num = m_ir_num; n_spur = m_spur;
      for (int i = 0; i < 8; i++)
        n_irr[i] = level ? ir[i] : (m_irr[i] | (ir[i] & !m_prev_ir[i]));
      if (first && cand >= 0 && (level || !(ir[cand] && !m_prev_ir[cand])))
        n_irr[cand] = 0;
      eoi_rot = 0; eoi_lvl = 0;
      if (eoi_cmd) begin
        if (eoi_specific) begin
          n_isr[cmd_level] = 0; eoi_rot = rot; eoi_lvl = cmd_level;
        end else if (svc >= 0) begin
          n_isr[svc] = 0; eoi_rot = rot; eoi_lvl = svc;
        end
      end
      if (second && aeoi && !m_spur) n_isr[m_ir_num] = 0;
      if (eoi_rot) n_low = eoi_lvl;
      else if (set_pri) n_low = cmd_level;
      else if (second && aeoi && rot) n_low = m_ir_num;
      if (first) begin
        n_in_ack = 1;
        if (cand >= 0) begin
          n_isr[cand] = 1; n_ir_num = cand; n_spur = 0;
        end else begin
          n_ir_num = 7; n_spur = 1;
        end
      end
      if (second) n_in_ack = 0;
      m_int = want && !n_in_ack;
      m_irr = n_irr; m_isr = n_isr; m_low = n_low; m_in_ack = n_in_ack;
      m_ir_num = n_ir_num; m_spur = n_spur;
      m_prev_ir = ir; m_inta_prev = inta_n;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      checks += 4;
      if (irr !== m_irr) begin
        failures++; $display("FAIL model_irr t=%0t got=%h want=%h", $time, irr, m_irr);
      end
      if (isr !== m_isr) begin
        failures++; $display("FAIL model_isr t=%0t got=%h want=%h", $time, isr, m_isr);
      end
      if (ir_num !== m_ir_num[2:0]) begin
        failures++; $display("FAIL model_ir_num t=%0t got=%0d want=%0d", $time, ir_num, m_ir_num);
      end
      if (internal_int !== m_int) begin
        failures++; $display("FAIL model_int t=%0t got=%b want=%b", $time, internal_int, m_int);
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string name, logic [7:0] got, logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic pulse_ir(logic [7:0] v);
    ir = v; tick();
    ir = '0; tick();
  endtask

  task automatic ack_pair();
    inta_n = 1'b0; tick();
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    inta_n = 1'b1; tick();
  endtask

  task automatic eoi(logic specific, logic [2:0] lvl);
    eoi_cmd = 1'b1; eoi_specific = specific; cmd_level = lvl; tick();
    eoi_cmd = 1'b0; eoi_specific = 1'b0; tick();
  endtask

  task automatic set_priority(logic [2:0] lvl);
    set_pri = 1'b1; cmd_level = lvl; tick();
    set_pri = 1'b0; tick();
  endtask

  initial begin
    tick(2);
    reset = 1'b0;
    chk("reset_irr", irr, 8'h00);
    chk("reset_isr", isr, 8'h00);
    chk("reset_ir_num", {5'b0, ir_num}, 8'h00);
    chk("reset_int", {7'b0, internal_int}, 8'h00);

    // Edge mode: IR3 then IR5, acknowledge IR3, non-specific EOI.
    ir = 8'h08; tick();
    ir = 8'h20; tick();
    ir = 8'h00; tick();
    chk("t1_int", {7'b0, internal_int}, 8'h01);
    chk("t1_irr", irr, 8'h28);
    inta_n = 1'b0; tick();
    inta_n = 1'b1; tick();
    chk("t1_ir_num", {5'b0, ir_num}, 8'h03);
    chk("t1_isr", isr, 8'h08);
    chk("t1_irr_after_ack", irr, 8'h20);
    inta_n = 1'b0; tick();
    inta_n = 1'b1; tick(2);
    chk("t1_int_held", {7'b0, internal_int}, 8'h00);
    eoi(1'b0, 3'd0);
    chk("t1_isr_eoi", isr, 8'h00);
    chk("t1_int_ir5", {7'b0, internal_int}, 8'h01);
    ack_pair();
    chk("t1_isr_ir5", isr, 8'h20);

    // Nesting: IR2 preempts IR5, IR6 does not.
    pulse_ir(8'h04);
    chk("t2_int", {7'b0, internal_int}, 8'h01);
    ack_pair();
    chk("t2_ir_num", {5'b0, ir_num}, 8'h02);
    chk("t2_isr", isr, 8'h24);
    pulse_ir(8'h40); tick();
    chk("t2_int_ir6", {7'b0, internal_int}, 8'h00);
    eoi(1'b0, 3'd0);
    eoi(1'b0, 3'd0);
    chk("t2_isr_clear", isr, 8'h00);
    ack_pair();
    eoi(1'b0, 3'd0);

    // Masked request and spurious acknowledge.
    mask = 8'h10;
    pulse_ir(8'h10); tick();
    chk("t3_irr", irr, 8'h10);
    chk("t3_int", {7'b0, internal_int}, 8'h00);
    ack_pair();
    chk("t3_ir_num", {5'b0, ir_num}, 8'h07);
    chk("t3_isr", isr, 8'h00);
    mask = 8'h00;
    ack_pair();
    eoi(1'b0, 3'd0);

    // AEOI with rotate.
    aeoi = 1'b1; rot = 1'b1;
    pulse_ir(8'h01);
    ack_pair();
    chk("t4_isr", isr, 8'h00);
    pulse_ir(8'h03);
    ack_pair();
    chk("t4_ir_num", {5'b0, ir_num}, 8'h01);
    ack_pair();
    chk("t4_ir_num_second", {5'b0, ir_num}, 8'h00);
    aeoi = 1'b0; rot = 1'b0;

    // Specific EOI and set-priority.
    set_priority(3'd7);
    pulse_ir(8'h08);
    ack_pair();
    pulse_ir(8'h04);
    ack_pair();
    chk("t5_isr_nested", isr, 8'h0C);
    eoi(1'b1, 3'd3);
    chk("t5_isr_spec", isr, 8'h04);
    set_priority(3'd4);
    pulse_ir(8'h28);
    inta_n = 1'b0; tick();
    inta_n = 1'b1; tick();
    chk("t5_ir_num", {5'b0, ir_num}, 8'h05);
    chk("t5_isr", isr, 8'h24);
    inta_n = 1'b0; tick();
    inta_n = 1'b1; tick();
    eoi(1'b0, 3'd0);
    eoi(1'b0, 3'd0);
    ack_pair();
    eoi(1'b0, 3'd0);
    set_priority(3'd7);

    // Level mode and reset between INTA_ pulses.
    level = 1'b1; ir = 8'h02; tick(2);
    chk("t6_int", {7'b0, internal_int}, 8'h01);
    inta_n = 1'b0; tick();
    chk("t6_irr_cleared", irr, 8'h00);
    inta_n = 1'b1; tick();
    chk("t6_irr_reset", irr, 8'h02);
    reset = 1'b1; tick();
    chk("t6_rst_irr", irr, 8'h00);
    chk("t6_rst_isr", isr, 8'h00);
    chk("t6_rst_ir_num", {5'b0, ir_num}, 8'h00);
    chk("t6_rst_int", {7'b0, internal_int}, 8'h00);
    reset = 1'b0; level = 1'b0; ir = 8'h00; tick();
    inta_n = 1'b0; tick();
    inta_n = 1'b1; tick();
    chk("t6_idle_after_reset", {5'b0, ir_num}, 8'h07);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
